// File: rtl/cond_unit_e_pkg.sv
// Shared definitions for the execute-stage conditional-execution unit:
// condition codes, NZCV bit positions and FlagWriteE bit meanings.
package cond_unit_e_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWriteE[FW_NZ] enables the N,Z pair, FlagWriteE[FW_CV] the C,V pair.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_unit_e_cond_check.sv
// Purely combinational condition check: evaluates a 4-bit condition field
// against a registered {N,Z,C,V} flag word.
module cond_check
    import cond_unit_e_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    flags_t f;
    logic   n_eq_v;

    assign f      = flags_t'(flags);
    assign n_eq_v = (f.n == f.v);

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = f.z;
            COND_NE: pass = ~f.z;
            COND_CS: pass = f.c;
            COND_CC: pass = ~f.c;
            COND_MI: pass = f.n;
            COND_PL: pass = ~f.n;
            COND_VS: pass = f.v;
            COND_VC: pass = ~f.v;
            COND_HI: pass = f.c & ~f.z;
            COND_LS: pass = ~f.c | f.z;
            COND_GE: pass = n_eq_v;
            COND_LT: pass = ~n_eq_v;
            COND_GT: pass = ~f.z & n_eq_v;
            COND_LE: pass = f.z | ~n_eq_v;
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // reserved encoding never executes
        endcase
    end

endmodule

// File: rtl/cond_unit_e.sv
// Execute-stage conditional-execution unit: NZCV flag register, condition
// gating of control strobes. Optional statistics counters under COND_STATS_EN.
module cond_unit_e
    import cond_unit_e_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    output logic             PCSrcGE,
    output logic             RegWriteGE,
    output logic             MemWriteGE,
    output logic             BranchTakenE,
    output logic             CondExE,
    output logic [3:0]       FlagsE,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    logic [3:0] flags_reg;
    logic       cond_pass;
    logic       cond_ex;

    // Judged on the registered flags only: no ALUFlags bypass.
    cond_check u_cond_check (
        .cond  (CondE),
        .flags (flags_reg),
        .pass  (cond_pass)
    );

    assign cond_ex      = ValidE & cond_pass & ~reset;
    assign CondExE      = cond_ex;
    assign PCSrcGE      = PCSrcE    & cond_ex;
    assign RegWriteGE   = RegWriteE & cond_ex;
    assign MemWriteGE   = MemWriteE & cond_ex;
    assign BranchTakenE = BranchE   & cond_ex;
    assign FlagsE       = flags_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= '0;
        end else begin
            if (FlagWriteE[FW_NZ] && cond_ex) begin
                flags_reg[FLAG_N] <= ALUFlags[FLAG_N];
                flags_reg[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagWriteE[FW_CV] && cond_ex) begin
                flags_reg[FLAG_C] <= ALUFlags[FLAG_C];
                flags_reg[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] squash_cnt_reg;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else if (ValidE) begin
            if (cond_ex) begin
                if (exec_cnt_reg != '1)
                    exec_cnt_reg <= exec_cnt_reg + CNT_ONE;
            end else begin
                if (squash_cnt_reg != '1)
                    squash_cnt_reg <= squash_cnt_reg + CNT_ONE;
            end
        end
    end

    assign ExecCnt   = exec_cnt_reg;
    assign SquashCnt = squash_cnt_reg;
`else
    assign ExecCnt   = '0;
    assign SquashCnt = '0;
`endif

endmodule

// File: doc/cond_unit_e.md
Name: cond_unit_e

Overview:
- Execute-stage conditional-execution unit, directly downstream of the decode/execute pipeline register.
- Holds the architectural NZCV flag register and evaluates CondE against it.
- Gates PCSrcE/RegWriteE/MemWriteE/BranchE and the flag writes before they enter the execute/memory register.
- Combinational gating plus a sequential flag register and optional statistics counters.

Parameters:
- CNT_W, 16, width of the optional executed/squashed statistics counters (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ValidE  in  1  execute-stage slot holds a real instruction (0 = bubble)
- PCSrcE  in  1  decoded PC-write request
- RegWriteE  in  1  decoded register-write request
- MemWriteE  in  1  decoded memory-write request
- BranchE  in  1  decoded branch
- FlagWriteE  in  2  [1] = write N,Z; [0] = write C,V
- CondE  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from the execute-stage ALU, this cycle
- PCSrcGE  out  1  gated PC-write
- RegWriteGE  out  1  gated register-write
- MemWriteGE  out  1  gated memory-write
- BranchTakenE  out  1  BranchE & CondExE
- CondExE  out  1  condition passed and ValidE
- FlagsE  out  4  current flag register {N,Z,C,V}
- ExecCnt  out  CNT_W  instructions executed (optional feature)
- SquashCnt  out  CNT_W  valid instructions squashed by condition (optional feature)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Flag register: 4 bits, {N,Z,C,V} at bits [3:0]. Reset value 4'b0000, taking effect at the first rising clk edge with reset=1.
- Condition evaluation uses the registered FlagsE, never ALUFlags. An instruction that writes flags and tests a condition is judged on the pre-update flags.
- CondE decode:
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 reserved = never (0)
- CondExE = ValidE & condpass.
- Gated outputs = respective input & CondExE; combinational, zero added latency.
- During reset=1, all gated outputs and CondExE are forced 0.
- Flag update at posedge clk, when not in reset:
  - N,Z <= ALUFlags[3:2] if FlagWriteE[1] & CondExE.
  - C,V <= ALUFlags[1:0] if FlagWriteE[0] & CondExE.
  - Otherwise each pair holds.
  - Pairs update independently; both may update in the same cycle.
- FlagWriteE with a failed condition or ValidE=0 leaves flags unchanged.
- Back-to-back flag writers: the second instruction sees the first's result one cycle later via the register. No bypass.
- Reset asserted mid-stream clears flags at that edge. Inputs in that cycle have no effect.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined:
  - Two CNT_W-bit counters, reset to 0.
  - Each cycle with ValidE=1: ExecCnt+1 if CondExE, else SquashCnt+1.
  - Both counters saturate at all-ones (no wrap).
- Undefined:
  - Counters absent.
  - ExecCnt and SquashCnt driven constant 0; ports remain.

Decomposition:
- Shared package:
  - Condition-code constants (EQ..AL, NV = 4'hF).
  - Flag bit indices (N=3, Z=2, C=1, V=0).
  - FlagWrite bit meanings.
- Sub-module cond_check: purely combinational, (CondE, FlagsE) -> condpass. Instantiated once. Reusable by a future branch predictor check.

Test Plan:
- Reset: reset=1 one cycle -> FlagsE=0000, all gated outputs 0. Then CondE=0 (EQ), ValidE=1, RegWriteE=1 -> RegWriteGE=0 (Z=0).
- Flag write: CondE=14, FlagWriteE=11, ALUFlags=0100, ValidE=1 -> next cycle FlagsE=0100. Then CondE=0, MemWriteE=1 -> MemWriteGE=1.
- Split write: FlagsE=0100, FlagWriteE=01, ALUFlags=1011, AL -> FlagsE=0111 (N,Z held, C,V updated).
- Squash: FlagsE=0000, CondE=1 (NE), BranchE=1, PCSrcE=1, FlagWriteE=11 -> BranchTakenE=1. Then CondE=0, FlagWriteE=11, ALUFlags=1111 -> CondExE=0, flags unchanged.
- Signed conditions and bubbles: FlagsE=1000 (N!=V) -> LT passes, GE fails, LE passes, GT fails. CondE=15 -> CondExE=0. ValidE=0 with AL -> all gated outputs 0.
- COND_STATS_EN: 3 executed + 2 squashed + 1 bubble -> ExecCnt=3, SquashCnt=2. With CNT_W=2, 5 executed -> ExecCnt=3 (saturated).
